// File: rtl/traffic_phase_scheduler.sv
// Three-phase traffic signal scheduler: MAIN, TURN, SIDE with
// actuated green (gap-out / max-out), yellow and all-red clearance,
// round-robin service of pending demand and emergency preemption.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 7,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] req,
    input  logic       emg,
    input  logic [1:0] emg_ph,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [2:0] grant,
    output logic [1:0] st
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    localparam logic [1:0] PH_MAIN = 2'd0;
    localparam logic [1:0] PH_TURN = 2'd1;
    localparam logic [1:0] PH_SIDE = 2'd2;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [3:0] C_AR_LAST   = 4'(ALLRED_T - 1);
    localparam logic [3:0] C_Y_LAST    = 4'(YELLOW_T - 1);
    localparam logic [3:0] C_GMIN_LAST = 4'(GREEN_MIN - 1);
    localparam logic [3:0] C_GMAX_LAST = 4'(GREEN_MAX - 1);
    localparam logic [3:0] C_GMAX      = 4'(GREEN_MAX);

    function automatic logic [2:0] ph_onehot(input logic [1:0] p);
        case (p)
            PH_MAIN: return 3'b001;
            PH_TURN: return 3'b010;
            PH_SIDE: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ph_inc(input logic [1:0] p);
        return (p == PH_SIDE) ? PH_MAIN : p + 2'd1;
    endfunction

    state_t     r_st;
    state_t     w_st_nx;
    logic [1:0] r_cur;
    logic [1:0] w_cur_nx;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nx;
    logic [2:0] r_pend;
    logic [2:0] w_pend_nx;

    logic [2:0] r_grant;
    logic [2:0] r_m1;
    logic [2:0] r_m2;
    logic [2:0] r_mt;
    logic [2:0] r_s;
    logic [2:0] w_grant_nx;
    logic [2:0] w_m1_nx;
    logic [2:0] w_m2_nx;
    logic [2:0] w_mt_nx;
    logic [2:0] w_s_nx;

    logic [1:0] w_emg_ph;
    logic [1:0] w_rr_p1;
    logic [1:0] w_rr_p2;
    logic [1:0] w_sel_ph;
    logic [2:0] w_cur_oh;
    logic       w_other_pend;
    logic       w_req_cur;
    logic [2:0] w_serve;
    logic [2:0] w_on;

    assign w_emg_ph     = (emg_ph == 2'd3) ? PH_MAIN : emg_ph;
    assign w_cur_oh     = ph_onehot(r_cur);
    assign w_other_pend = |(r_pend & ~w_cur_oh);
    assign w_req_cur    = |(req & w_cur_oh);
    assign w_rr_p1      = ph_inc(r_cur);
    assign w_rr_p2      = ph_inc(w_rr_p1);

    // Phase to serve on leaving all-red: emergency target, else round-robin after cur.
    always_comb begin
        w_sel_ph = PH_MAIN;
        if (emg) begin
            w_sel_ph = w_emg_ph;
        end else if (|(r_pend & ph_onehot(w_rr_p1))) begin
            w_sel_ph = w_rr_p1;
        end else if (|(r_pend & ph_onehot(w_rr_p2))) begin
            w_sel_ph = w_rr_p2;
        end else if (|(r_pend & w_cur_oh)) begin
            w_sel_ph = r_cur;
        end
    end

    // Next-state, phase, tick counter and pending-demand logic.
    always_comb begin
        w_st_nx   = r_st;
        w_cur_nx  = r_cur;
        w_cnt_nx  = r_cnt;
        // demand for the phase already green is not latched
        w_pend_nx = r_pend | (req & ((r_st == ST_GREEN) ? ~w_cur_oh : 3'b111));
        if (r_cur > PH_SIDE) begin
            w_st_nx  = ST_ALLRED;
            w_cur_nx = PH_MAIN;
            w_cnt_nx = '0;
        end else begin
            case (r_st)
                ST_ALLRED: begin
                    if (tick) begin
                        if (r_cnt == C_AR_LAST) begin
                            w_st_nx   = ST_GREEN;
                            w_cur_nx  = w_sel_ph;
                            w_cnt_nx  = '0;
                            // clearing after the set above makes clear win
                            w_pend_nx = w_pend_nx & ~ph_onehot(w_sel_ph);
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end
                end
                ST_GREEN: begin
                    if (emg && (w_emg_ph != r_cur)) begin
                        w_st_nx  = ST_YELLOW;
                        w_cnt_nx = '0;
                    end else if (tick) begin
                        // >= on max-out covers a count saturated during an unopposed hold
                        if (!emg && w_other_pend &&
                            (((r_cnt >= C_GMIN_LAST) && !w_req_cur) || (r_cnt >= C_GMAX_LAST))) begin
                            w_st_nx  = ST_YELLOW;
                            w_cnt_nx = '0;
                        end else if (r_cnt < C_GMAX) begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (tick) begin
                        if (r_cnt == C_Y_LAST) begin
                            w_st_nx  = ST_ALLRED;
                            w_cnt_nx = '0;
                        end else begin
                            w_cnt_nx = r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    w_st_nx  = ST_ALLRED;
                    w_cur_nx = PH_MAIN;
                    w_cnt_nx = '0;
                end
            endcase
        end
    end

    // Lamp and grant values derived from the next state so they switch with st.
    always_comb begin
        w_grant_nx = '0;
        w_m1_nx    = LAMP_R;
        w_m2_nx    = LAMP_R;
        w_mt_nx    = LAMP_R;
        w_s_nx     = LAMP_R;
        w_serve    = ph_onehot(w_cur_nx);
        w_on       = (w_st_nx == ST_GREEN) ? LAMP_G : LAMP_Y;
        if ((w_st_nx == ST_GREEN) || (w_st_nx == ST_YELLOW)) begin
            if (w_serve[0] || w_serve[1]) w_m1_nx = w_on;
            if (w_serve[0])               w_m2_nx = w_on;
            if (w_serve[1])               w_mt_nx = w_on;
            if (w_serve[2])               w_s_nx  = w_on;
        end
        if (w_st_nx == ST_GREEN) begin
            w_grant_nx = w_serve;
        end
    end

    // State register with asynchronous reset to all-red, MAIN, nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st   <= ST_ALLRED;
            r_cur  <= PH_MAIN;
            r_cnt  <= '0;
            r_pend <= '0;
        end else begin
            r_st   <= w_st_nx;
            r_cur  <= w_cur_nx;
            r_cnt  <= w_cnt_nx;
            r_pend <= w_pend_nx;
        end
    end

    // Registered lamp drive and grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_m1    <= LAMP_R;
            r_m2    <= LAMP_R;
            r_mt    <= LAMP_R;
            r_s     <= LAMP_R;
        end else begin
            r_grant <= w_grant_nx;
            r_m1    <= w_m1_nx;
            r_m2    <= w_m2_nx;
            r_mt    <= w_mt_nx;
            r_s     <= w_s_nx;
        end
    end

    assign st       = r_st;
    assign grant    = r_grant;
    assign light_M1 = r_m1;
    assign light_M2 = r_m2;
    assign light_MT = r_mt;
    assign light_S  = r_s;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized scoreboard bench for traffic_phase_scheduler: a phase-level
// reference model predicts the outputs after each clock edge, a monitor
// pops and compares them after the edge.
module tb_traffic_phase_scheduler;

    localparam int GMIN  = 5;
    localparam int GMAX  = 7;
    localparam int YT    = 2;
    localparam int AT    = 1;
    localparam int NCYC  = 3200;

    localparam int MODE_RED    = 0;
    localparam int MODE_GREEN  = 1;
    localparam int MODE_YELLOW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] req;
    logic       emg;
    logic [1:0] emg_ph;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [2:0] grant;
    logic [1:0] st;

    traffic_phase_scheduler #(
        .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX),
        .YELLOW_T (YT),
        .ALLRED_T (AT)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .req     (req),
        .emg     (emg),
        .emg_ph  (emg_ph),
        .light_M1(light_M1),
        .light_M2(light_M2),
        .light_MT(light_MT),
        .light_S (light_S),
        .grant   (grant),
        .st      (st)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] grant;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model: current signal mode, phase on display, ticks spent, demand memory
    int       m_mode;
    int       m_phase;
    int       m_elapsed;
    bit [2:0] m_pend;

    // which phases give right of way to each approach (0 M1, 1 M2, 2 MT, 3 S)
    function automatic bit serves(int a, int p);
        case (a)
            0:       return (p == 0) || (p == 1);
            1:       return p == 0;
            2:       return p == 1;
            default: return p == 2;
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t       o;
        logic [2:0] l[4];
        for (int a = 0; a < 4; a++) begin
            if (m_mode != MODE_RED && serves(a, m_phase))
                l[a] = (m_mode == MODE_GREEN) ? 3'b001 : 3'b010;
            else
                l[a] = 3'b100;
        end
        o.st    = 2'(m_mode);
        o.grant = (m_mode == MODE_GREEN) ? 3'(1 << m_phase) : 3'b000;
        o.m1    = l[0];
        o.m2    = l[1];
        o.mt    = l[2];
        o.s     = l[3];
        return o;
    endfunction

    function automatic void model_reset();
        m_mode    = MODE_RED;
        m_phase   = 0;
        m_elapsed = 0;
        m_pend    = '0;
    endfunction

    // advance the model across one clock edge with the given inputs
    function automatic void model_step(bit r, bit t, logic [2:0] rq, bit e, logic [1:0] eph);
        bit [2:0] np;
        int       target;
        int       chosen;
        bit       found;
        bit       others;
        if (r) begin
            model_reset();
            return;
        end
        np = m_pend;
        for (int i = 0; i < 3; i++)
            if (rq[i] && !(m_mode == MODE_GREEN && i == m_phase)) np[i] = 1'b1;
        target = (eph == 2'd3) ? 0 : int'(eph);
        case (m_mode)
            MODE_RED: begin
                if (t) begin
                    if (m_elapsed + 1 >= AT) begin
                        chosen = 0;
                        if (e) begin
                            chosen = target;
                        end else begin
                            found = 1'b0;
                            for (int k = 1; k <= 3; k++) begin
                                if (!found && m_pend[(m_phase + k) % 3]) begin
                                    chosen = (m_phase + k) % 3;
                                    found  = 1'b1;
                                end
                            end
                        end
                        m_mode     = MODE_GREEN;
                        m_phase    = chosen;
                        m_elapsed  = 0;
                        np[chosen] = 1'b0;
                    end else begin
                        m_elapsed++;
                    end
                end
            end
            MODE_GREEN: begin
                others = 1'b0;
                for (int j = 0; j < 3; j++)
                    if (j != m_phase && m_pend[j]) others = 1'b1;
                if (e && target != m_phase) begin
                    m_mode    = MODE_YELLOW;
                    m_elapsed = 0;
                end else if (t) begin
                    if (!e && others &&
                        ((m_elapsed >= GMIN - 1 && !rq[m_phase]) || m_elapsed >= GMAX - 1)) begin
                        m_mode    = MODE_YELLOW;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
            end
            default: begin
                if (t) begin
                    if (m_elapsed + 1 >= YT) begin
                        m_mode    = MODE_RED;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
            end
        endcase
        m_pend = np;
    endfunction

    obs_t mon_exp;
    obs_t mon_act;

    // monitor: after each rising edge compare DUT outputs with the oldest prediction
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {st, grant, light_M1, light_M2, light_MT, light_S};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d act st=%0d grant=%b M1=%b M2=%b MT=%b S=%b required st=%0d grant=%b M1=%b M2=%b MT=%b S=%b",
                         cyc, mon_act.st, mon_act.grant, mon_act.m1, mon_act.m2, mon_act.mt, mon_act.s,
                         mon_exp.st, mon_exp.grant, mon_exp.m1, mon_exp.m2, mon_exp.mt, mon_exp.s);
            end
        end
    end

    obs_t red_obs;
    obs_t now_obs;
    int   rst_trig[3] = '{700, 1600, 2500};
    int   rst_k       = 0;
    bit   hold0       = 1'b0;
    bit   do_rst;

    initial begin
        red_obs = {2'd0, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100};
        rst     = 1'b1;
        tick    = 1'b0;
        req     = '0;
        emg     = 1'b0;
        emg_ph  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        now_obs = {st, grant, light_M1, light_M2, light_MT, light_S};
        checks++;
        if (now_obs !== red_obs) begin
            errors++;
            $display("FAIL reset_state act=%h required=%h", now_obs, red_obs);
        end

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            rst = 1'b0;
            if (c < 200) begin
                tick = (c % 4 == 0);
                req  = '0;
                emg  = 1'b0;
            end else begin
                if ((c / 500) % 2 == 1) tick = ($urandom_range(2, 0) == 0);
                else                    tick = (c % 4 == 0);
                if ($urandom_range(49, 0) == 0) hold0 = !hold0;
                req[0] = hold0 || ($urandom_range(19, 0) == 0);
                req[1] = ($urandom_range(24, 0) == 0);
                req[2] = ($urandom_range(24, 0) == 0);
                if (!emg && $urandom_range(199, 0) == 0) begin
                    emg    = 1'b1;
                    emg_ph = 2'($urandom_range(3, 0));
                end else if (emg && $urandom_range(59, 0) == 0) begin
                    emg = 1'b0;
                end
            end
            do_rst = (rst_k < 3) && (c >= rst_trig[rst_k]) && (m_mode == MODE_YELLOW);
            if (do_rst) begin
                rst_k++;
                #2;
                rst = 1'b1;
                #1;
                now_obs = {st, grant, light_M1, light_M2, light_MT, light_S};
                checks++;
                if (now_obs !== red_obs) begin
                    errors++;
                    $display("FAIL async_reset cyc=%0d act=%h required=%h", c, now_obs, red_obs);
                end
            end
            model_step(rst, tick, req, emg, emg_ph);
            exp_q.push_back(model_obs());
        end

        @(negedge clk);
        tick = 1'b0;
        req  = '0;
        emg  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d required=0", exp_q.size());
        end
        checks++;
        if (rst_k != 3) begin
            errors++;
            $display("FAIL reset_events act=%0d required=3", rst_k);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 5, minimum green length in ticks.
REQ-002 Parameter GREEN_MAX, default 7, maximum green length in ticks while another phase is pending.
REQ-003 Parameter YELLOW_T, default 2, yellow length in ticks.
REQ-004 Parameter ALLRED_T, default 1, all-red clearance length in ticks.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 tick  in  1  one-cycle timing strobe, 1 per second; all timers advance only when tick=1.
REQ-008 req  in  3  demand per phase: [0] MAIN (M1+M2 through), [1] TURN (M1+MT), [2] SIDE (S).
REQ-009 emg  in  1  emergency preemption request, level.
REQ-010 emg_ph  in  2  emergency target phase (0..2); value 3 treated as 0.
REQ-011 light_M1, light_M2, light_MT, light_S  out  3 each  registered lamp drive: 100 red, 010 yellow, 001 green.
REQ-012 grant  out  3  one-hot phase currently green; 000 outside GREEN.
REQ-013 st  out  2  FSM state: 0 ALLRED, 1 GREEN, 2 YELLOW.

Function
REQ-014 FSM states: ALLRED, GREEN, YELLOW; register cur[1:0] holds the served/next phase; register cnt[3:0] counts ticks in state.
REQ-015 A timed state of length N SHALL last exactly N ticks: on tick, cnt==N-1 -> transition with cnt<=0, else cnt<=cnt+1; without tick, cnt holds.
REQ-016 pend[2:0] SHALL set bit i on any clk with req[i]=1, except i==cur while st==GREEN; bit i SHALL clear on the edge entering GREEN of phase i.
REQ-017 ALLRED -> GREEN after ALLRED_T ticks; next phase = emg_ph if emg=1, else first pending phase in round-robin order after cur (cur+1, cur+2, cur), else MAIN.
REQ-018 In GREEN with other pending bits clear and emg=0, the phase SHALL hold green indefinitely; cnt saturates at GREEN_MAX.
REQ-019 In GREEN with another phase pending, on tick: leave to YELLOW when cnt>=GREEN_MIN-1 and req[cur]=0 (gap-out), or when cnt==GREEN_MAX-1 (max-out).
REQ-020 emg=1 with emg_ph!=cur in GREEN SHALL force YELLOW on the next clk edge regardless of tick or GREEN_MIN; emg=1 with emg_ph==cur SHALL hold GREEN with no max-out.
REQ-021 YELLOW -> ALLRED after YELLOW_T ticks; emg never shortens YELLOW or ALLRED.
REQ-022 Lamps: GREEN MAIN -> M1=M2=001, MT=S=100; GREEN TURN -> M1=MT=001, M2=S=100; GREEN SIDE -> S=001, others 100; YELLOW -> approaches green in cur show 010, others 100; ALLRED -> all 100.
REQ-023 Lamps and grant SHALL be registered and change on the same edge as st; never two conflicting phases green, never green directly after green of another phase.
REQ-024 Simultaneous req set and pend clear for same bit on GREEN entry: clear wins.

Reset
REQ-025 rst=1 SHALL immediately force st=ALLRED, cur=MAIN, cnt=0, pend=000, grant=000, all lamps 100.
REQ-026 rst mid-GREEN or mid-YELLOW SHALL abandon the phase with no yellow; after release, first GREEN occurs after ALLRED_T ticks.
REQ-027 Illegal st or cur encoding SHALL recover to ALLRED, cur=MAIN on the next edge.

Verification
REQ-028 Reset release, no req, tick every 4 clk -> ALLRED 1 tick, then MAIN green (grant=001) held 20+ ticks.
REQ-029 MAIN green, req[2] pulsed 1 clk at tick 1, req[0]=0 -> YELLOW at tick 5, ALLRED 2 ticks later, SIDE green (S=001, grant=100) 1 tick after.
REQ-030 MAIN green, req[0] held 1, req[1] pulsed -> max-out: M1,M2=010 after 7 ticks, then TURN green.
REQ-031 pend=110 at ALLRED end, cur=MAIN -> TURN served first, SIDE next; each pend bit clears on its GREEN entry.
REQ-032 SIDE green cnt=1, emg=1 emg_ph=0 without tick -> YELLOW next clk, full 2-tick yellow, 1-tick all-red, MAIN green held while emg=1.
REQ-033 rst asserted mid-YELLOW -> all lamps 100 same cycle asynchronously; pend=000.
